// File: rtl/axi_ddc_cfg_master.sv
// AXI4-Lite configuration master for a bank of DDC channels.
// Turns one command into a short sequence of register writes, or into a single
// register read, and reports completion with a one-cycle rsp_done pulse.
// Every AXI output comes from a flop, so no AXI input reaches an AXI output
// through combinational logic. Each wait state has a bounded cycle budget so a
// hung slave cannot lock the block up.
module axi_ddc_cfg_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 5,
  parameter int N_CH               = 4,
  parameter int TIMEOUT            = 255,
  localparam int CW                = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_op,
  input  logic [CW-1:0]                   cmd_ch,
  input  logic [19:0]                     cmd_pinc,
  input  logic [19:0]                     cmd_poff,
  input  logic [17:0]                     cmd_len,
  input  logic [2:0]                      cmd_raddr,
  output logic                            rsp_done,
  output logic                            rsp_err,
  output logic [31:0]                     rsp_data,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

  // One bit per encodable channel index, set where the channel actually exists.
  function automatic logic [(1<<CW)-1:0] ch_ok_mask();
    logic [(1<<CW)-1:0] m;
    m = '0;
    for (int i = 0; i < (1 << CW); i++) m[i] = (i < N_CH);
    return m;
  endfunction

  localparam logic [(1<<CW)-1:0] CH_OK = ch_ok_mask();

  // Register index n lives at byte address n*4.
  function automatic logic [AW-1:0] reg_addr(input logic [2:0] idx);
    return AW'({idx, 2'b00});
  endfunction

  // Target register of write number `step` for a given op. The channel
  // config sequence ends on reg0, which commits the new settings.
  function automatic logic [2:0] wr_reg(input logic [1:0] op, input logic [1:0] step);
    logic [2:0] r;
    r = 3'd0;
    case (op)
      2'd0: begin
        case (step)
          2'd0:    r = 3'd1;
          2'd1:    r = 3'd2;
          default: r = 3'd0;
        endcase
      end
      2'd1:    r = 3'd3;
      2'd2:    r = 3'd4;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // Data word of write number `step` for a given op.
  function automatic logic [DW-1:0] wr_data(input logic [1:0] op, input logic [1:0] step,
                                             input logic [CW-1:0] ch, input logic [19:0] pinc,
                                             input logic [19:0] poff, input logic [17:0] len);
    logic [DW-1:0] d;
    d = '0;
    case (op)
      2'd0: begin
        case (step)
          2'd0:    d = DW'(pinc);
          2'd1:    d = DW'(poff);
          default: d = DW'(ch);
        endcase
      end
      2'd1:    d = DW'(len);
      2'd2:    d = DW'(1);
      default: d = '0;
    endcase
    return d;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        step_q, step_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [AW-1:0]     awaddr_q, awaddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [AW-1:0]     araddr_q, araddr_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_data_q, rsp_data_d;

  logic [1:0]        op_q;
  logic [CW-1:0]     ch_q;
  logic [19:0]       pinc_q, poff_q;
  logic [17:0]       len_q;

  logic              aw_hs, w_hs, timed_out, last_write;
  logic [1:0]        step_nx;

  // Capture the command fields on accept so the inputs may change afterwards.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      op_q   <= '0;
      ch_q   <= '0;
      pinc_q <= '0;
      poff_q <= '0;
      len_q  <= '0;
    end else if (state_q == IDLE && cmd_valid) begin
      op_q   <= cmd_op;
      ch_q   <= cmd_ch;
      pinc_q <= cmd_pinc;
      poff_q <= cmd_poff;
      len_q  <= cmd_len;
    end
  end

  // State register plus every flopped AXI and response output.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      step_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      araddr_q   <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      araddr_q   <= araddr_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Next-state logic and next values of all flopped outputs.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    araddr_d   = araddr_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    aw_hs      = awvalid_q & M_AXI_AWREADY;
    w_hs       = wvalid_q & M_AXI_WREADY;
    timed_out  = (cnt_q == CNT_W'(TIMEOUT - 1));
    last_write = (op_q != 2'd0) || (step_q == 2'd2);
    step_nx    = step_q + 2'd1;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rsp_err_d = 1'b0;
          step_d    = 2'd0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_op == 2'd0 && !CH_OK[cmd_ch]) begin
            rsp_err_d = 1'b1;
            state_d   = DONE;
          end else if (cmd_op == 2'd3) begin
            araddr_d  = reg_addr(cmd_raddr);
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end else begin
            awaddr_d  = reg_addr(wr_reg(cmd_op, 2'd0));
            wdata_d   = wr_data(cmd_op, 2'd0, cmd_ch, cmd_pinc, cmd_poff, cmd_len);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR;
          end
        end
      end
      WADDR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = WRESP;
        end else if (timed_out) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rsp_err_d = 1'b1;
          state_d   = DONE;
        end
      end
      WRESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != 2'b00) begin
            rsp_err_d = 1'b1;
            state_d   = DONE;
          end else if (last_write) begin
            state_d = DONE;
          end else begin
            step_d    = step_nx;
            awaddr_d  = reg_addr(wr_reg(op_q, step_nx));
            wdata_d   = wr_data(op_q, step_nx, ch_q, pinc_q, poff_q, len_q);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR;
          end
        end else if (timed_out) begin
          bready_d  = 1'b0;
          rsp_err_d = 1'b1;
          state_d   = DONE;
        end
      end
      RADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end else if (timed_out) begin
          arvalid_d = 1'b0;
          rsp_err_d = 1'b1;
          state_d   = DONE;
        end
      end
      RDATA: begin
        if (M_AXI_RVALID) begin
          rready_d   = 1'b0;
          rsp_data_d = 32'(M_AXI_RDATA);
          rsp_err_d  = (M_AXI_RRESP != 2'b00);
          state_d    = DONE;
        end else if (timed_out) begin
          rready_d  = 1'b0;
          rsp_err_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
  end

  assign cmd_ready     = (state_q == IDLE);
  assign rsp_done      = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign rsp_err       = rsp_err_q;
  assign rsp_data      = rsp_data_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_ddc_cfg_master.sv
// Directed bench for axi_ddc_cfg_master with a small behavioural AXI4-Lite
// slave whose ready delays, error responses and hang behaviour are set per step.
module tb_axi_ddc_cfg_master;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int N_CH = 3;
  localparam int CW   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_ch;
  logic [19:0]   cmd_pinc, cmd_poff;
  logic [17:0]   cmd_len;
  logic [2:0]    cmd_raddr;
  logic          rsp_done, rsp_err, busy;
  logic [31:0]   rsp_data;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  int checks = 0;
  int errors = 0;

  // Slave configuration
  int          aw_delay = 0, w_delay = 0, b_err_idx = -1;
  bit          b_hang = 1'b0;
  logic [31:0] rdata_cfg = 32'h0;
  logic [1:0]  rresp_cfg = 2'b00;

  // Slave log
  logic [31:0] wr_addr_log [8];
  logic [31:0] wr_data_log [8];
  int          wr_n = 0, ar_n = 0;
  logic [31:0] ar_log = 32'h0;

  // Slave internal state
  bit          aw_got, w_got, ar_got;
  int          aw_wait, w_wait;
  logic [AW-1:0] cur_awaddr, awaddr_s, araddr_s;
  logic [DW-1:0] cur_wdata, wdata_s;
  logic        awvalid_s, wvalid_s, bready_s, arvalid_s, rready_s;

  always #5 clk = ~clk;

  axi_ddc_cfg_master #(.N_CH(N_CH)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_ch(cmd_ch),
    .cmd_pinc(cmd_pinc), .cmd_poff(cmd_poff), .cmd_len(cmd_len), .cmd_raddr(cmd_raddr),
    .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_data(rsp_data), .busy(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Behavioural slave: acts on the falling edge so its outputs are stable at the
  // next rising edge; handshakes are detected from values held over that edge.
  always @(negedge clk) begin
    if (!rst_n || !busy) begin
      aw_got = 0; w_got = 0; ar_got = 0; aw_wait = 0; w_wait = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
      arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
    end else begin
      if (awvalid_s && awready) begin aw_got = 1; cur_awaddr = awaddr_s; aw_wait = 0; end
      if (wvalid_s && wready) begin w_got = 1; cur_wdata = wdata_s; w_wait = 0; end
      if (bvalid && bready_s) begin
        bvalid = 0;
        if (wr_n < 8) begin
          wr_addr_log[wr_n] = 32'(cur_awaddr);
          wr_data_log[wr_n] = cur_wdata;
        end
        wr_n++;
        aw_got = 0; w_got = 0;
      end
      if (arvalid_s && arready) begin ar_log = 32'(araddr_s); ar_n++; ar_got = 1; end
      if (rvalid && rready_s) begin rvalid = 0; ar_got = 0; end
      awready = 0;
      if (awvalid) begin awready = (aw_wait >= aw_delay); aw_wait++; end
      wready = 0;
      if (wvalid) begin wready = (w_wait >= w_delay); w_wait++; end
      if (aw_got && w_got && !bvalid && !b_hang) begin
        bvalid = 1;
        bresp = (wr_n == b_err_idx) ? 2'b10 : 2'b00;
      end
      arready = arvalid;
      if (ar_got && !rvalid) begin rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg; end
    end
    awvalid_s = awvalid; awaddr_s = awaddr; wvalid_s = wvalid; wdata_s = wdata;
    bready_s = bready; arvalid_s = arvalid; araddr_s = araddr; rready_s = rready;
  end

  // Absolute bound on run time in case a wait in the sequence misbehaves.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [CW-1:0] ch, input logic [19:0] pinc,
                               input logic [19:0] poff, input logic [17:0] len, input logic [2:0] raddr);
    wr_n = 0;
    ar_n = 0;
    @(negedge clk);
    cmd_op = op; cmd_ch = ch; cmd_pinc = pinc; cmd_poff = poff; cmd_len = len; cmd_raddr = raddr;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic waitDone(output bit ok, output logic err, output logic [31:0] data,
                          output int ncyc, output int nbready, output int naw);
    ok = 0; err = 1'bx; data = 'x; ncyc = 0; nbready = 0; naw = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      ncyc++;
      if (bready) nbready++;
      if (awvalid) naw++;
      if (rsp_done) begin
        ok = 1; err = rsp_err; data = rsp_data;
        break;
      end
    end
  endtask

  bit          ok;
  logic        err;
  logic [31:0] data;
  int          ncyc, nbr, naw, aw_bad, w_bad;

  initial begin
    cmd_valid = 0; cmd_op = 0; cmd_ch = 0; cmd_pinc = 0; cmd_poff = 0; cmd_len = 0; cmd_raddr = 0;

    // Reset state
    #23;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_awvalid", 32'(awvalid), 0);
    checkOutput("rst_rsp_done", 32'(rsp_done), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // Channel config, zero-wait slave
    applyStimulus(2'd0, 2'd2, 20'h12345, 20'h00ABC, 18'd0, 3'd0);
    checkOutput("cfg_wstrb", 32'(wstrb), 32'hF);
    checkOutput("cfg_awprot", 32'(awprot), 0);
    waitDone(ok, err, data, ncyc, nbr, naw);
    checkOutput("cfg_done", 32'(ok), 1);
    checkOutput("cfg_err", 32'(err), 0);
    @(negedge clk); #1;
    checkOutput("cfg_done_pulse", 32'(rsp_done), 0);
    checkOutput("cfg_ready_again", 32'(cmd_ready), 1);
    checkOutput("cfg_nwrites", wr_n, 3);
    checkOutput("cfg_a0", wr_addr_log[0], 32'h04);
    checkOutput("cfg_d0", wr_data_log[0], 32'h00012345);
    checkOutput("cfg_a1", wr_addr_log[1], 32'h08);
    checkOutput("cfg_d1", wr_data_log[1], 32'h00000ABC);
    checkOutput("cfg_a2", wr_addr_log[2], 32'h00);
    checkOutput("cfg_d2", wr_data_log[2], 32'h00000002);

    // AWREADY held off 20 cycles, WREADY at cycle 3
    aw_delay = 20; w_delay = 3;
    applyStimulus(2'd0, 2'd1, 20'h11111, 20'h22222, 18'd0, 3'd0);
    aw_bad = 0; w_bad = 0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (awvalid !== 1'b1 || awaddr !== 5'h04) aw_bad++;
      if (k <= 3 && wvalid !== 1'b1) w_bad++;
      if (k >= 4 && wvalid !== 1'b0) w_bad++;
    end
    checkOutput("slow_aw_stable", aw_bad, 0);
    checkOutput("slow_w_drop", w_bad, 0);
    waitDone(ok, err, data, ncyc, nbr, naw);
    checkOutput("slow_done", 32'(ok), 1);
    checkOutput("slow_err", 32'(err), 0);
    @(negedge clk); #1;
    checkOutput("slow_nwrites", wr_n, 3);
    checkOutput("slow_d0", wr_data_log[0], 32'h00011111);
    checkOutput("slow_d1", wr_data_log[1], 32'h00022222);
    checkOutput("slow_a2", wr_addr_log[2], 32'h00);
    checkOutput("slow_d2", wr_data_log[2], 32'h00000001);
    aw_delay = 0; w_delay = 0;

    // Register read, OKAY response
    rdata_cfg = 32'h00000100; rresp_cfg = 2'b00;
    applyStimulus(2'd3, 2'd0, 20'h0, 20'h0, 18'd0, 3'd3);
    waitDone(ok, err, data, ncyc, nbr, naw);
    checkOutput("rd_done", 32'(ok), 1);
    checkOutput("rd_data", data, 32'h00000100);
    checkOutput("rd_err", 32'(err), 0);
    @(negedge clk); #1;
    checkOutput("rd_araddr", ar_log, 32'h0C);
    checkOutput("rd_nwrites", wr_n, 0);

    // Register read, SLVERR response
    rdata_cfg = 32'hDEADBEEF; rresp_cfg = 2'b10;
    applyStimulus(2'd3, 2'd0, 20'h0, 20'h0, 18'd0, 3'd5);
    waitDone(ok, err, data, ncyc, nbr, naw);
    checkOutput("rderr_data", data, 32'hDEADBEEF);
    checkOutput("rderr_err", 32'(err), 1);
    @(negedge clk); #1;
    checkOutput("rderr_araddr", ar_log, 32'h14);
    rresp_cfg = 2'b00;

    // Error response on the second write aborts the sequence
    b_err_idx = 1;
    applyStimulus(2'd0, 2'd0, 20'h00005, 20'h00006, 18'd0, 3'd0);
    waitDone(ok, err, data, ncyc, nbr, naw);
    checkOutput("berr_done", 32'(ok), 1);
    checkOutput("berr_err", 32'(err), 1);
    @(negedge clk); #1;
    checkOutput("berr_nwrites", wr_n, 2);
    checkOutput("berr_a1", wr_addr_log[1], 32'h08);
    repeat (5) @(negedge clk);
    checkOutput("berr_err_hold", 32'(rsp_err), 1);
    b_err_idx = -1;

    // Out-of-range channel: no traffic, straight to completion
    applyStimulus(2'd0, 2'd3, 20'h00001, 20'h00002, 18'd0, 3'd0);
    waitDone(ok, err, data, ncyc, nbr, naw);
    checkOutput("badch_latency", ncyc, 1);
    checkOutput("badch_err", 32'(err), 1);
    checkOutput("badch_awvalid_seen", naw, 0);
    @(negedge clk); #1;
    checkOutput("badch_nwrites", wr_n, 0);

    // Hung slave: BVALID never comes
    b_hang = 1'b1;
    applyStimulus(2'd1, 2'd0, 20'h0, 20'h0, 18'd7, 3'd0);
    waitDone(ok, err, data, ncyc, nbr, naw);
    checkOutput("hang_done", 32'(ok), 1);
    checkOutput("hang_err", 32'(err), 1);
    checkOutput("hang_wresp_cycles", nbr, 255);
    b_hang = 1'b0;
    @(negedge clk); #1;
    checkOutput("hang_bready_low", 32'(bready), 0);
    applyStimulus(2'd2, 2'd0, 20'h0, 20'h0, 18'd0, 3'd0);
    waitDone(ok, err, data, ncyc, nbr, naw);
    checkOutput("resync_err", 32'(err), 0);
    checkOutput("resync_data_hold", data, 32'hDEADBEEF);
    @(negedge clk); #1;
    checkOutput("resync_nwrites", wr_n, 1);
    checkOutput("resync_a0", wr_addr_log[0], 32'h10);
    checkOutput("resync_d0", wr_data_log[0], 32'h00000001);

    // Asynchronous reset in the middle of a write
    aw_delay = 50;
    applyStimulus(2'd0, 2'd1, 20'hABCDE, 20'h13579, 18'd0, 3'd0);
    repeat (3) @(negedge clk);
    checkOutput("mid_awvalid_pre", 32'(awvalid), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_awvalid", 32'(awvalid), 0);
    checkOutput("mid_wvalid", 32'(wvalid), 0);
    checkOutput("mid_awaddr", 32'(awaddr), 0);
    checkOutput("mid_wdata", wdata, 0);
    checkOutput("mid_busy", 32'(busy), 0);
    checkOutput("mid_rsp_data", rsp_data, 0);
    checkOutput("mid_rsp_err", 32'(rsp_err), 0);
    checkOutput("mid_cmd_ready", 32'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    aw_delay = 0;
    @(posedge clk); #1;
    checkOutput("mid_ready_after", 32'(cmd_ready), 1);
    applyStimulus(2'd1, 2'd0, 20'h0, 20'h0, 18'd1000, 3'd0);
    waitDone(ok, err, data, ncyc, nbr, naw);
    checkOutput("len_done", 32'(ok), 1);
    checkOutput("len_err", 32'(err), 0);
    @(negedge clk); #1;
    checkOutput("len_nwrites", wr_n, 1);
    checkOutput("len_a0", wr_addr_log[0], 32'h0C);
    checkOutput("len_d0", wr_data_log[0], 32'h000003E8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_ddc_cfg_master.md
AXI_DDC_CFG_MASTER -- requirements
Module: axi_ddc_cfg_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 5, AXI address width.
REQ-003 SHALL have parameter N_CH, default 4, number of DDC channels; channel index width CW = $clog2(N_CH).
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum cycles spent in any single wait state.
REQ-005 SHALL have one clock and one reset. Reset is asynchronous and active-low.
REQ-006 Ports, in this order:
- M_AXI_ACLK, in, 1: the single clock.
- M_AXI_ARESETN, in, 1: asynchronous, active-low reset.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: command accepted when high together with cmd_valid.
- cmd_op, in, 2: 0 = channel config, 1 = accumulation length, 2 = soft resync, 3 = register read.
- cmd_ch, in, CW: channel index for op 0.
- cmd_pinc, in, 20: phase increment for op 0.
- cmd_poff, in, 20: phase offset for op 0.
- cmd_len, in, 18: accumulation length for op 1.
- cmd_raddr, in, 3: register index for op 3.
- rsp_done, out, 1: one-cycle pulse at command completion.
- rsp_err, out, 1: error flag, valid while rsp_done is high.
- rsp_data, out, 32: read data, valid while rsp_done is high for op 3.
- busy, out, 1: high from command accept until rsp_done.
- AXI4-Lite master ports, standard widths: M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY.

Function
REQ-007 cmd_ready SHALL equal (state==IDLE). The command SHALL be registered on accept.
REQ-008 FSM states SHALL be IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
REQ-009 Register index n SHALL map to byte address n*4. AWPROT and ARPROT SHALL be 0. WSTRB SHALL be 4'hF.
REQ-010 Op 0 SHALL issue three writes, strictly in this order:
- reg1 = {12'b0, pinc}
- reg2 = {12'b0, poff}
- reg0 = {zero-extended ch}
The reg0 write is the commit write and SHALL be last.
REQ-011 Op 1 SHALL write reg3 = {14'b0, len}. Op 2 SHALL write reg4 = 32'h1. Op 3 SHALL read register cmd_raddr.
REQ-012 Op 0 with cmd_ch >= N_CH SHALL issue no AXI traffic and SHALL go IDLE->DONE with rsp_err=1.
REQ-013 WADDR SHALL assert AWVALID and WVALID in the same cycle.
- Each valid SHALL drop independently on its own handshake.
- Address and data SHALL stay stable until the handshake.
- The FSM SHALL leave WADDR once both handshakes are complete, including when they occur in the same or different cycles.
REQ-014 WRESP SHALL hold BREADY=1 until BVALID. BRESP != 0 SHALL set the error and go to DONE, skipping the remaining writes of the sequence. BRESP == 0 SHALL issue the next write, or go to DONE after the last write.
REQ-015 RADDR SHALL hold ARVALID until ARREADY. RDATA SHALL hold RREADY=1 until RVALID, capture RDATA into rsp_data, and set the error if RRESP != 0.
REQ-016 A per-state counter SHALL clear on every state entry.
- If TIMEOUT cycles elapse without the awaited handshake, the block SHALL drop all AXI valid/ready outputs, set rsp_err=1, and go to DONE.
- This is deliberate hung-slave recovery.
REQ-017 DONE SHALL last exactly one cycle, assert rsp_done, then return to IDLE. Command-to-command throughput SHALL include this DONE cycle.
REQ-018 rsp_data SHALL hold its last captured value. rsp_err SHALL hold until the next accept.
REQ-019 No combinational path SHALL exist from any AXI input to any AXI output.

Reset
REQ-020 Asserting reset, including mid-transaction, SHALL immediately force:
- state = IDLE
- all AXI valid/ready outputs = 0, addresses and data = 0
- rsp_done = 0, rsp_err = 0, rsp_data = 0, busy = 0, counter = 0
REQ-021 After deassertion, cmd_ready SHALL be 1 on the first clock edge.

Verification
REQ-022 Op 0, ch=2, pinc=0x12345, poff=0x00ABC, zero-wait slave -> writes to 0x04/0x00012345, then 0x08/0x00000ABC, then 0x00/0x00000002; one rsp_done pulse; rsp_err=0.
REQ-023 Slave holds AWREADY low 20 cycles while WREADY arrives at cycle 3 -> WVALID drops after cycle 3; AWVALID and AWADDR stay stable through cycle 20; the sequence completes without error.
REQ-024 Op 3, raddr=3, slave returns RDATA=0x00000100 with RRESP=0 -> rsp_data=0x00000100 at rsp_done; rsp_err=0.
REQ-025 Op 0, slave returns BRESP=2'b10 on the second write -> no write to 0x00 occurs; rsp_done with rsp_err=1.
REQ-026 Slave never asserts BVALID with TIMEOUT=255 -> rsp_done with rsp_err=1 after 255 cycles in WRESP; BREADY=0 afterwards; the next command proceeds normally.
REQ-027 Reset asserted while AWVALID=1 -> all outputs take their REQ-020 values asynchronously; op 1 with len=1000 after release -> a single write 0x0C/0x000003E8.
